nullformer_banked: RTL and testbench
====================================

NULLFORMER_BANKED -- requirements
Module: nullformer_banked

Interface
REQ-001 SHALL provide parameter NCH, default 4: number of antenna channels, range 2..8.
REQ-002 SHALL provide parameter WIDTH, default 14: signed sample width per channel.
REQ-003 SHALL provide parameter CFWIDTH, default 16: signed coefficient width, Q1.(CFWIDTH-1).
REQ-004 SHALL provide parameter NT, default 5: FIR taps per non-direct channel, range 1..16.
REQ-005 SHALL provide parameter OUT_WIDTH, default 16: signed saturated output width.
REQ-006 SHALL provide parameter DIRECT_CH, default 0: index of the unfiltered reference channel.
REQ-007 SHALL provide ports, in this order:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  sample strobe; all channels are sampled together.
- adc_concat  in  NCH*WIDTH  channel c occupies bits [(c+1)*WIDTH-1 : c*WIDTH].
- cf_wr  in  1  coefficient write strobe, shadow bank.
- cf_addr  in  clog2((NCH-1)*NT)  address = j*NT+k; j = non-direct channel ordinal, k = tap.
- cf_data  in  CFWIDTH  coefficient value.
- cf_commit  in  1  bank-swap request pulse.
- nshift  in  5  output arithmetic right shift.
- out_valid  out  1  output strobe.
- nf_out  out  OUT_WIDTH  null-former output.
- sat  out  1  saturation flag, qualified by out_valid.
- cf_pending  out  1  swap requested, not yet applied.
- wr_err  out  1  one-cycle pulse for a dropped write.
- bank_sel  out  1  active coefficient bank.

Function
REQ-008 Delay lines SHALL advance only on cycles with in_valid=1; gaps SHALL NOT alter state or output history.
REQ-009 For each non-direct channel j: y_j[n] = sum over k=0..NT-1 of h_j[k]*x_j[n-k], using the active bank.
REQ-010 The direct channel SHALL be delayed by D=NT/2 (integer division) samples and scaled by 2^(CFWIDTH-1).
REQ-011 Full-precision sum SHALL be the direct term plus all y_j. Width ACC = WIDTH+CFWIDTH+clog2(NT)+clog2(NCH). No intermediate overflow or truncation.
REQ-012 The sum SHALL be arithmetically right-shifted by nshift (floor), then saturated to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-013 sat SHALL be 1 exactly when clipping occurred for that output.
REQ-014 out_valid SHALL assert exactly 4 clk cycles after the accepting in_valid cycle, one pulse per sample. nf_out and sat SHALL hold between pulses.
REQ-015 cf_wr with an in-range address SHALL write the shadow bank (!bank_sel). cf_wr with an out-of-range address SHALL be ignored, with no wr_err.
REQ-016 Swap FSM, IDLE: cf_commit=1 -> PENDING; cf_pending=1 from the next cycle.
REQ-017 Swap FSM, PENDING: on the first cycle with in_valid=1, bank_sel SHALL toggle at that edge and the FSM SHALL return to IDLE. The sample accepted on that cycle and all later samples SHALL use the new bank for every tap.
REQ-018 Swap FSM, PENDING: cf_wr SHALL be dropped and SHALL pulse wr_err. cf_commit SHALL be ignored.
REQ-019 cf_commit and in_valid in the same cycle while IDLE SHALL enter PENDING only. The swap SHALL take effect on the next in_valid.
REQ-020 A non-swapped bank SHALL retain its contents; after a swap, the old active bank becomes the shadow bank with its contents unchanged.

Reset
REQ-021 resetn=0 SHALL clear both banks, all delay lines and the pipeline. It SHALL set bank_sel=0, FSM=IDLE, cf_pending=0, out_valid=0, nf_out=0, sat=0, wr_err=0.
REQ-022 Reset mid-pipeline or mid-PENDING SHALL discard in-flight samples and the pending swap. No out_valid SHALL appear for samples accepted before reset.

Verification
Defaults apply throughout: NCH=4, WIDTH=14, CFWIDTH=16, NT=5, OUT_WIDTH=16, DIRECT_CH=0, D=2.
REQ-023 Direct path: after reset, nshift=15, impulse 1000 on ch0 at sample 0, then zeros -> third output (sample 2) = 1000, all others = 0, each out_valid 4 cycles after its in_valid.
REQ-024 FIR path: write addr 0 (ch1, k=0) = 16384 and addr 5 (ch2, k=0) = -16384, commit, nshift=15, ch1=2000 and ch2=600 at one sample -> that output = 700; bank_sel=1.
REQ-025 Saturation: nshift=0, ch0=8191 held -> nf_out=32767, sat=1; ch0=-8192 -> nf_out=-32768, sat=1; ch0=0 -> sat=0.
REQ-026 Swap timing: commit with in_valid=0 for 10 cycles -> cf_pending=1 and bank_sel unchanged throughout; first in_valid -> bank_sel toggles and cf_pending=0 next cycle. cf_wr during PENDING -> wr_err pulse and shadow contents unchanged.
REQ-027 Reset and gaps: resetn=0 for one cycle while PENDING with samples in flight -> no further out_valid, bank_sel=0, cf_pending=0. Random in_valid gaps give output identical to the gap-free reference model.

Source files
------------

// File: rtl/nullformer_banked.sv
// Banked-coefficient null-former: FIR-filtered auxiliary channels summed onto a delayed,
// scaled reference channel, with a swap FSM that applies a new coefficient bank on a sample boundary.
module nullformer_banked #(
    parameter int NCH       = 4,
    parameter int WIDTH     = 14,
    parameter int CFWIDTH   = 16,
    parameter int NT        = 5,
    parameter int OUT_WIDTH = 16,
    parameter int DIRECT_CH = 0,
    localparam int AW = (((NCH - 1) * NT) > 1) ? $clog2((NCH - 1) * NT) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [NCH*WIDTH-1:0]   adc_concat,
    input  logic                   cf_wr,
    input  logic [AW-1:0]          cf_addr,
    input  logic [CFWIDTH-1:0]     cf_data,
    input  logic                   cf_commit,
    input  logic [4:0]             nshift,
    output logic                   out_valid,
    output logic [OUT_WIDTH-1:0]   nf_out,
    output logic                   sat,
    output logic                   cf_pending,
    output logic                   wr_err,
    output logic                   bank_sel
);

    localparam int NCF = (NCH - 1) * NT;
    localparam int D   = NT / 2;
    localparam int PW  = WIDTH + CFWIDTH;
    localparam int ACC = WIDTH + CFWIDTH + $clog2(NT) + $clog2(NCH);

    localparam logic signed [ACC-1:0] OMAX = {{(ACC-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC-1:0] OMIN = {{(ACC-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_PENDING} state_e;

    state_e state_q, state_d;
    logic   bank_sel_q, bank_sel_d;
    logic   wr_err_q;
    logic   wr_ok;

    logic signed [CFWIDTH-1:0] coef_q [2][NCF];
    logic signed [WIDTH-1:0]   tap_q  [NCH][NT];
    logic signed [PW-1:0]      prod_q [NCH-1][NT];
    logic signed [WIDTH-1:0]   dir_q;
    logic signed [ACC-1:0]     sum_d, sum_q, shifted;
    logic [OUT_WIDTH-1:0]      out_d, nf_out_q;
    logic                      sat_d, sat_q;
    logic                      v1_q, v2_q, v3_q, out_valid_q;

    // Non-direct ordinal j skips over the reference channel index.
    function automatic int unsigned chan_of(input int unsigned j);
        return (j < DIRECT_CH) ? j : j + 1;
    endfunction

    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        case (state_q)
            S_IDLE: begin
                if (cf_commit) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (in_valid) begin
                    state_d    = S_IDLE;
                    bank_sel_d = ~bank_sel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            bank_sel_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            wr_err_q   <= cf_wr && (state_q == S_PENDING);
        end
    end

    assign wr_ok = cf_wr && (state_q == S_IDLE) && (int'(cf_addr) < NCF);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned i = 0; i < NCF; i++)
                    coef_q[b][i] <= '0;
        end else if (wr_ok) begin
            coef_q[~bank_sel_q][cf_addr] <= cf_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v1_q <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++)
                for (int unsigned k = 0; k < NT; k++)
                    tap_q[c][k] <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    tap_q[c][0] <= adc_concat[c*WIDTH +: WIDTH];
                    for (int unsigned k = 1; k < NT; k++)
                        tap_q[c][k] <= tap_q[c][k-1];
                end
            end
        end
    end

    // Products are formed the cycle after acceptance, so a swap made on the accepting
    // edge is already visible to every tap of that sample and to none of the older ones.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            v2_q  <= 1'b0;
            dir_q <= '0;
            for (int unsigned j = 0; j < NCH - 1; j++)
                for (int unsigned k = 0; k < NT; k++)
                    prod_q[j][k] <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                dir_q <= tap_q[DIRECT_CH][D];
                for (int unsigned j = 0; j < NCH - 1; j++)
                    for (int unsigned k = 0; k < NT; k++)
                        prod_q[j][k] <= coef_q[bank_sel_q][j*NT + k] * tap_q[chan_of(j)][k];
            end
        end
    end

    always_comb begin
        sum_d = ACC'(dir_q) <<< (CFWIDTH - 1);
        for (int unsigned j = 0; j < NCH - 1; j++)
            for (int unsigned k = 0; k < NT; k++)
                sum_d = sum_d + ACC'(prod_q[j][k]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v3_q  <= 1'b0;
            sum_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) sum_q <= sum_d;
        end
    end

    always_comb begin
        shifted = sum_q >>> nshift;
        out_d   = shifted[OUT_WIDTH-1:0];
        sat_d   = 1'b0;
        if (shifted > OMAX) begin
            out_d = OMAX[OUT_WIDTH-1:0];
            sat_d = 1'b1;
        end else if (shifted < OMIN) begin
            out_d = OMIN[OUT_WIDTH-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            nf_out_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= v3_q;
            if (v3_q) begin
                nf_out_q <= out_d;
                sat_q    <= sat_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign nf_out     = nf_out_q;
    assign sat        = sat_q;
    assign cf_pending = (state_q == S_PENDING);
    assign wr_err     = wr_err_q;
    assign bank_sel   = bank_sel_q;

endmodule

// File: tb/tb_nullformer_banked.sv
// Directed and random checks of nullformer_banked against a sample-indexed reference model.
module tb_nullformer_banked;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [55:0] adc_concat = '0;
    logic        cf_wr = 1'b0;
    logic [3:0]  cf_addr = '0;
    logic [15:0] cf_data = '0;
    logic        cf_commit = 1'b0;
    logic [4:0]  nshift = 5'd15;
    logic        out_valid;
    logic [15:0] nf_out;
    logic        sat;
    logic        cf_pending;
    logic        wr_err;
    logic        bank_sel;

    always #5 clk = ~clk;

    nullformer_banked #(
        .NCH(4), .WIDTH(14), .CFWIDTH(16), .NT(5), .OUT_WIDTH(16), .DIRECT_CH(0)
    ) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .adc_concat(adc_concat),
        .cf_wr(cf_wr), .cf_addr(cf_addr), .cf_data(cf_data), .cf_commit(cf_commit),
        .nshift(nshift), .out_valid(out_valid), .nf_out(nf_out), .sat(sat),
        .cf_pending(cf_pending), .wr_err(wr_err), .bank_sel(bank_sel)
    );

    typedef struct {
        int unsigned due;
        longint      val;
        bit          s;
    } exp_t;

    int          n_checks = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    longint      mcoef [2][15];
    int          msel = 0;
    bit          mpend = 0;
    bit          exp_wrerr = 0;
    int          hist [4][$];
    exp_t        expq [$];
    longint      last_out = 0;
    bit          last_sat = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint xd(input int c, input int idx);
        if (idx < 0) return 0;
        return longint'(hist[c][idx]);
    endfunction

    task automatic accept(input int x0, input int x1, input int x2, input int x3);
        longint acc, sh;
        exp_t e;
        int n;
        hist[0].push_back(x0);
        hist[1].push_back(x1);
        hist[2].push_back(x2);
        hist[3].push_back(x3);
        n = hist[0].size() - 1;
        acc = xd(0, n - 2) * 32768;
        for (int c = 1; c < 4; c++)
            for (int k = 0; k < 5; k++)
                acc += mcoef[msel][(c - 1) * 5 + k] * xd(c, n - k);
        sh = acc >>> nshift;
        e.s = 1'b0;
        if (sh > 32767) begin
            sh = 32767; e.s = 1'b1;
        end else if (sh < -32768) begin
            sh = -32768; e.s = 1'b1;
        end
        e.val = sh;
        e.due = cyc + 4;
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check("bank_sel", bank_sel, msel);
        check("cf_pending", cf_pending, mpend);
        check("wr_err", wr_err, exp_wrerr);
        if (expq.size() > 0 && expq[0].due == cyc) begin
            check("out_valid_hi", out_valid, 1);
            check("nf_out", $signed(nf_out), expq[0].val);
            check("sat", sat, expq[0].s);
            last_out = expq[0].val;
            last_sat = expq[0].s;
            void'(expq.pop_front());
        end else begin
            check("out_valid_lo", out_valid, 0);
            check("nf_out_hold", $signed(nf_out), last_out);
            check("sat_hold", sat, last_sat);
        end
    endtask

    task automatic step(input bit iv, input int x0, input int x1, input int x2, input int x3,
                        input bit wr = 0, input int addr = 0, input int data = 0, input bit commit = 0);
        in_valid   = iv;
        adc_concat = {x3[13:0], x2[13:0], x1[13:0], x0[13:0]};
        cf_wr      = wr;
        cf_addr    = addr[3:0];
        cf_data    = data[15:0];
        cf_commit  = commit;
        exp_wrerr  = mpend && wr;
        if (wr && !mpend && addr < 15) mcoef[1 - msel][addr] = longint'(data);
        if (mpend) begin
            if (iv) begin
                msel  = 1 - msel;
                mpend = 0;
            end
        end else if (commit) begin
            mpend = 1;
        end
        if (iv) accept(x0, x1, x2, x3);
        tick();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        cf_wr     = 1'b0;
        cf_commit = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 15; i++)
                mcoef[b][i] = 0;
        msel = 0;
        mpend = 0;
        exp_wrerr = 0;
        for (int c = 0; c < 4; c++) hist[c].delete();
        expq.delete();
        last_out = 0;
        last_sat = 0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic set_shift(input int v);
        repeat (6) idle();
        nshift = v[4:0];
    endtask

    initial begin
        int xs0, xs1, xs2, xs3, addr, data;
        bit iv, wr, cm;

        do_reset();
        do_reset();

        // Direct path impulse
        set_shift(15);
        step(1, 1000, 0, 0, 0);
        repeat (7) step(1, 0, 0, 0, 0);

        // FIR path through a committed bank
        set_shift(15);
        step(0, 0, 0, 0, 0, 1, 0, 16384);
        step(0, 0, 0, 0, 0, 1, 5, -16384);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        step(1, 0, 2000, 600, 0);
        set_shift(15);
        check("fir_out_700", $signed(nf_out), 700);
        check("fir_bank_sel", bank_sel, 1);

        // Saturation at both rails
        set_shift(0);
        repeat (6) step(1, 8191, 0, 0, 0);
        set_shift(0);
        check("sat_pos_out", $signed(nf_out), 32767);
        check("sat_pos_flag", sat, 1);
        repeat (6) step(1, -8192, 0, 0, 0);
        set_shift(0);
        check("sat_neg_out", $signed(nf_out), -32768);
        check("sat_neg_flag", sat, 1);
        repeat (6) step(1, 0, 0, 0, 0);
        set_shift(15);
        check("sat_clear", sat, 0);

        // Long pending window, dropped write, then swap on first sample
        step(0, 0, 0, 0, 0, 1, 10, 8000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (10) idle();
        step(0, 0, 0, 0, 0, 1, 10, -5);
        step(1, 0, 0, 0, 3000);
        repeat (4) step(1, 0, 0, 0, 1500);
        set_shift(15);

        // Commit with a sample in IDLE only arms the swap
        step(0, 0, 0, 0, 0, 1, 3, 12000);
        step(1, 0, 700, 0, 0, 0, 0, 0, 1);
        step(1, 0, 700, 0, 0);
        set_shift(15);

        // Reset while pending with samples in flight
        step(1, 500, 100, 200, 300);
        step(1, 400, 100, 200, 300);
        step(1, 300, 100, 200, 300, 0, 0, 0, 1);
        do_reset();
        repeat (8) idle();

        // Random traffic with gaps, writes and swaps
        for (int sub = 0; sub < 3; sub++) begin
            set_shift(12 + int'($urandom_range(0, 8)));
            for (int i = 0; i < 150; i++) begin
                iv   = ($urandom_range(0, 9) < 6);
                xs0  = int'($urandom_range(0, 16383)) - 8192;
                xs1  = int'($urandom_range(0, 16383)) - 8192;
                xs2  = int'($urandom_range(0, 16383)) - 8192;
                xs3  = int'($urandom_range(0, 16383)) - 8192;
                wr   = ($urandom_range(0, 4) == 0);
                addr = int'($urandom_range(0, 15));
                data = int'($urandom_range(0, 65535)) - 32768;
                cm   = ($urandom_range(0, 19) == 0);
                step(iv, xs0, xs1, xs2, xs3, wr, addr, data, cm);
            end
        end
        set_shift(15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
